// File: rtl/noc_pkg.sv
// Shared definitions for the mesh-router input port: flit types, output-port
// indices and input-port FSM state encoding.
package noc_pkg;

    localparam logic [1:0] FLIT_BODY     = 2'b00;
    localparam logic [1:0] FLIT_HEAD     = 2'b01;
    localparam logic [1:0] FLIT_TAIL     = 2'b10;
    localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_EAST  = 3'd1;
    localparam logic [2:0] PORT_WEST  = 3'd2;
    localparam logic [2:0] PORT_NORTH = 3'd3;
    localparam logic [2:0] PORT_SOUTH = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQUEST = 2'b01,
        ST_STREAM  = 2'b10
    } ipu_state_e;

    function automatic logic is_head_type(input logic [1:0] flit_type);
        case (flit_type)
            FLIT_HEAD, FLIT_HEADTAIL: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_tail_type(input logic [1:0] flit_type);
        case (flit_type)
            FLIT_TAIL, FLIT_HEADTAIL: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small power-of-two flit buffer; front entry is always visible on front_data.
module flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] front_data
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push_s, do_pop_s;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_q == {CNT_W{1'b0}});
    assign do_push_s  = push & ~full;
    assign do_pop_s   = pop & ~empty;
    assign front_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// Mesh-router input port: flit buffer, XY route computation from head flits,
// and the reserve/relieve handshake toward the switch controller.
module input_port_unit
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int COORD_WIDTH   = 2,
    parameter int X_COORD       = 0,
    parameter int Y_COORD       = 0,
    parameter int REQUEST_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    output logic                     routeRelieve,
    input  logic                     routeReserveStatus,
    output logic                     err_flit
);

    localparam logic [COORD_WIDTH-1:0] MY_X = COORD_WIDTH'(X_COORD);
    localparam logic [COORD_WIDTH-1:0] MY_Y = COORD_WIDTH'(Y_COORD);

    logic                     fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [DATA_WIDTH-1:0]    front_s;
    logic [1:0]               front_type_s;
    logic [COORD_WIDTH-1:0]   dest_x_s, dest_y_s;
    logic [REQUEST_WIDTH-1:0] route_s;
    ipu_state_e               state_q, state_d;
    logic [REQUEST_WIDTH-1:0] req_port_q, req_port_d;
    logic                     req_valid_s, valid_out_s, relieve_s, err_s;

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (valid_in),
        .push_data  (data_in),
        .pop        (fifo_pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .front_data (front_s)
    );

    assign front_type_s = front_s[DATA_WIDTH-1 -: 2];
    assign dest_x_s     = front_s[COORD_WIDTH-1:0];
    assign dest_y_s     = front_s[2*COORD_WIDTH-1:COORD_WIDTH];

    // Dimension-ordered route: X settled before Y is considered
    always_comb begin
        route_s = REQUEST_WIDTH'(PORT_LOCAL);
        if (dest_x_s > MY_X) begin
            route_s = REQUEST_WIDTH'(PORT_EAST);
        end else if (dest_x_s < MY_X) begin
            route_s = REQUEST_WIDTH'(PORT_WEST);
        end else if (dest_y_s > MY_Y) begin
            route_s = REQUEST_WIDTH'(PORT_NORTH);
        end else if (dest_y_s < MY_Y) begin
            route_s = REQUEST_WIDTH'(PORT_SOUTH);
        end else begin
            route_s = REQUEST_WIDTH'(PORT_LOCAL);
        end
    end

    // Packet FSM: next state, dequeue control and handshake outputs
    always_comb begin
        state_d     = state_q;
        req_port_d  = req_port_q;
        fifo_pop_s  = 1'b0;
        err_s       = 1'b0;
        relieve_s   = 1'b0;
        valid_out_s = 1'b0;
        req_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_empty_s) begin
                    state_d = ST_IDLE;
                end else if (is_head_type(front_type_s)) begin
                    req_port_d = route_s;
                    state_d    = ST_REQUEST;
                end else begin
                    // Orphan body/tail with no open path is dropped
                    fifo_pop_s = 1'b1;
                    err_s      = 1'b1;
                end
            end
            ST_REQUEST: begin
                req_valid_s = 1'b1;
                if (routeReserveStatus) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_REQUEST;
                end
            end
            ST_STREAM: begin
                req_valid_s = 1'b1;
                valid_out_s = ~fifo_empty_s;
                if (valid_out_s && ready_out) begin
                    fifo_pop_s = 1'b1;
                    if (is_tail_type(front_type_s)) begin
                        relieve_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and held output-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_port_q <= {REQUEST_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            req_port_q <= req_port_d;
        end
    end

    assign ready_in                 = ~fifo_full_s;
    assign data_out                 = front_s;
    assign valid_out                = valid_out_s;
    assign routeReserveRequestValid = req_valid_s;
    assign routeReserveRequest      = req_port_q;
    assign routeRelieve             = relieve_s;
    assign err_flit                 = err_s;

endmodule

// File: tb/tb_input_port_unit.sv
// Scoreboard bench for input_port_unit at router (1,1), FIFO_DEPTH=4.
module tb_input_port_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_out;
    logic        rv;
    logic [2:0]  req_port;
    logic        relieve;
    logic        status;
    logic        err_flit;

    typedef struct packed {
        logic [31:0] data;
        logic        tail;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] port_q[$];
    int         checks = 0;
    int         errors = 0;
    int         relieve_cnt = 0;
    int         err_cnt = 0;

    input_port_unit #(
        .DATA_WIDTH(32), .FIFO_DEPTH(4), .COORD_WIDTH(2),
        .X_COORD(1), .Y_COORD(1), .REQUEST_WIDTH(3)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .data_in                  (data_in),
        .valid_in                 (valid_in),
        .ready_in                 (ready_in),
        .data_out                 (data_out),
        .valid_out                (valid_out),
        .ready_out                (ready_out),
        .routeReserveRequestValid (rv),
        .routeReserveRequest      (req_port),
        .routeRelieve             (relieve),
        .routeReserveStatus       (status),
        .err_flit                 (err_flit)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] y,
                                       input logic [1:0] x, input logic [7:0] tag);
        return {t, 18'h0, tag, y, x};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Offer a flit until accepted; record its expected output if it should stream
    task automatic send(input logic [31:0] d, input logic keep, input logic tail);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        data_in = d;
        valid_in = 1'b1;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            n++;
        end
        #1;
        valid_in = 1'b0;
        if (!acc) timeout_fail("send");
        else if (keep) exp_q.push_back('{data: d, tail: tail});
    endtask

    task automatic wait_rv();
        int n;
        n = 0;
        while (!rv && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rv) timeout_fail("wait_request");
    endtask

    task automatic grant_pulse();
        status = 1'b1;
        @(posedge clk);
        #1;
        status = 1'b0;
    endtask

    task automatic wait_left(input int left);
        int n;
        n = 0;
        while (exp_q.size() > left && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > left) timeout_fail("wait_stream");
    endtask

    // Monitor: compares every output handshake and request rise against the queues
    initial begin
        exp_t e;
        logic prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_flit");
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out", data_out, e.data);
                        check("relieve_on_hs", 32'(relieve), 32'(e.tail));
                    end
                end else if (relieve) begin
                    check("relieve_no_hs", 32'(relieve), 32'd0);
                end
                if (relieve) relieve_cnt++;
                if (err_flit) err_cnt++;
                if (rv && !prev_rv) begin
                    if (port_q.size() == 0) timeout_fail("unexpected_request");
                    else check("route_port", 32'(req_port), 32'(port_q.pop_front()));
                end
                prev_rv = rv;
            end else begin
                prev_rv = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int e0;
        rst = 1'b0;
        valid_in = 1'b0;
        data_in = 32'h0;
        ready_out = 1'b0;
        status = 1'b0;
        #12;
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_rv", 32'(rv), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_req_port", 32'(req_port), 32'd0);
        check("rst_relieve_err", 32'({relieve, err_flit}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: H(2,1) B T -> EAST, request two cycles after head write
        ready_out = 1'b1;
        r0 = relieve_cnt;
        port_q.push_back(3'd1);
        send(mk(2'b01, 2'd1, 2'd2, 8'h11), 1'b1, 1'b0);
        check("rv_after_write", 32'(rv), 32'd0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h12), 1'b1, 1'b0);
        check("rv_t2", 32'(rv), 32'd1);
        check("req_east", 32'(req_port), 32'd1);
        send(mk(2'b10, 2'd0, 2'd0, 8'h13), 1'b1, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("no_valid_before_grant", 32'(valid_out), 32'd0);
        grant_pulse();
        check("valid_after_grant", 32'(valid_out), 32'd1);
        wait_left(0);
        check("rv_drop_after_tail", 32'(rv), 32'd0);
        check("relieve_count_t1", 32'(relieve_cnt - r0), 32'd1);

        // 2: HEADTAIL to (1,1) (0,1) (1,2) (1,0) -> LOCAL WEST NORTH SOUTH
        r0 = relieve_cnt;
        port_q.push_back(3'd0);
        port_q.push_back(3'd2);
        port_q.push_back(3'd3);
        port_q.push_back(3'd4);
        send(mk(2'b11, 2'd1, 2'd1, 8'h21), 1'b1, 1'b1);
        send(mk(2'b11, 2'd1, 2'd0, 8'h22), 1'b1, 1'b1);
        send(mk(2'b11, 2'd2, 2'd1, 8'h23), 1'b1, 1'b1);
        send(mk(2'b11, 2'd0, 2'd1, 8'h24), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_rv();
            grant_pulse();
            wait_left(3 - i);
            check("rv_gap", 32'(rv), 32'd0);
        end
        check("relieve_count_t2", 32'(relieve_cnt - r0), 32'd4);

        // 3: six flits, no grant yet; buffer fills after four
        port_q.push_back(3'd1);
        send(mk(2'b01, 2'd1, 2'd2, 8'h31), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h32), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h33), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h34), 1'b1, 1'b0);
        check("full_ready_in", 32'(ready_in), 32'd0);
        fork
            begin
                send(mk(2'b00, 2'd0, 2'd0, 8'h35), 1'b1, 1'b0);
                send(mk(2'b10, 2'd0, 2'd0, 8'h36), 1'b1, 1'b1);
            end
            begin
                repeat (3) begin
                    check("full_hold", 32'(ready_in), 32'd0);
                    @(posedge clk);
                    #1;
                end
                grant_pulse();
            end
        join
        wait_left(0);

        // 4: H(0,0) -> WEST, stall five cycles after the head
        r0 = relieve_cnt;
        ready_out = 1'b0;
        port_q.push_back(3'd2);
        send(mk(2'b01, 2'd0, 2'd0, 8'h41), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h42), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h43), 1'b1, 1'b0);
        send(mk(2'b10, 2'd0, 2'd0, 8'h44), 1'b1, 1'b1);
        wait_rv();
        grant_pulse();
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        repeat (5) begin
            check("stall_data", data_out, mk(2'b00, 2'd0, 2'd0, 8'h42));
            check("stall_valid", 32'(valid_out), 32'd1);
            @(posedge clk);
            #1;
        end
        check("stall_no_relieve", 32'(relieve_cnt - r0), 32'd0);
        ready_out = 1'b1;
        wait_left(0);
        check("relieve_count_t4", 32'(relieve_cnt - r0), 32'd1);

        // 5: stray BODY in IDLE is dropped
        e0 = err_cnt;
        send(mk(2'b00, 2'd2, 2'd2, 8'h51), 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("err_pulse_once", 32'(err_cnt - e0), 32'd1);
        check("err_no_request", 32'(rv), 32'd0);
        check("err_fifo_empty", 32'({ready_in, valid_out}), 32'b10);

        // 6: reset mid-packet after two flits streamed
        r0 = relieve_cnt;
        port_q.push_back(3'd1);
        send(mk(2'b01, 2'd1, 2'd3, 8'h61), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h62), 1'b1, 1'b0);
        send(mk(2'b00, 2'd0, 2'd0, 8'h63), 1'b1, 1'b0);
        send(mk(2'b10, 2'd0, 2'd0, 8'h64), 1'b1, 1'b1);
        wait_rv();
        grant_pulse();
        wait_left(2);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_rv", 32'(rv), 32'd0);
        check("mid_rst_valid_out", 32'(valid_out), 32'd0);
        check("mid_rst_ready_in", 32'(ready_in), 32'd1);
        check("mid_rst_req_port", 32'(req_port), 32'd0);
        check("mid_rst_data_out", data_out, 32'd0);
        check("mid_rst_relieve", 32'(relieve), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_relieve_on_reset", 32'(relieve_cnt - r0), 32'd0);
        check("total_relieves", 32'(relieve_cnt), 32'd7);
        check("ports_consumed", 32'(port_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_port_unit.md
# input_port_unit

Per-input-port front end of a mesh router: buffers incoming flits in a small FIFO, computes the XY output port from each head flit, and drives the request/relieve handshake of the router's switch controller. Once the switch controller grants the path, it streams the packet's flits toward the crossbar and releases the path on the tail flit. A router instantiates one per input port; each instance's request outputs feed one slot of the switch controller's `routeReserveRequestValid`, `routeReserveRequest` and `routeRelieve` vectors.

## Interface

**Parameters** (name, default, meaning)
- `DATA_WIDTH`, 32, flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] are the flit type.
- `FIFO_DEPTH`, 4, buffer entries. Must be a power of two, ≥2.
- `COORD_WIDTH`, 2, width of each X/Y coordinate.
- `X_COORD`, 0, this router's X position.
- `Y_COORD`, 0, this router's Y position.
- `REQUEST_WIDTH`, 3, output-port index width.

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock. Everything is rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `data_in` in DATA_WIDTH: upstream flit.
- `valid_in` in 1: upstream flit valid.
- `ready_in` out 1: buffer can accept a flit; equals ~full.
- `data_out` out DATA_WIDTH: flit toward the crossbar (FIFO head).
- `valid_out` out 1: data_out valid.
- `ready_out` in 1: crossbar/downstream accepts the flit.
- `routeReserveRequestValid` out 1: path request to the switch controller.
- `routeReserveRequest` out REQUEST_WIDTH: requested output port.
- `routeRelieve` out 1: one-cycle path-release pulse.
- `routeReserveStatus` in 1: one-cycle grant pulse from the switch controller.
- `err_flit` out 1: one-cycle pulse when a non-head flit is discarded in IDLE.

## Operation

**Flit types**
- 2'b01 = HEAD.
- 2'b00 = BODY.
- 2'b10 = TAIL.
- 2'b11 = HEADTAIL (single-flit packet).

**Head flit fields**
- dest X = [COORD_WIDTH-1:0].
- dest Y = [2*COORD_WIDTH-1:COORD_WIDTH].

**Port encoding:** LOCAL=0, EAST=1, WEST=2, NORTH=3, SOUTH=4.

**XY routing** (unsigned compares, X resolved first)
- destX > X_COORD → EAST; destX < X_COORD → WEST.
- Otherwise destY > Y_COORD → NORTH; destY < Y_COORD → SOUTH.
- Otherwise LOCAL.

**FIFO**
- Enqueue on `valid_in & ready_in`. Dequeue on any handshake or discard.
- Simultaneous enqueue and dequeue is allowed when not full.
- No enqueue when full; no bypass path when empty.

**FSM** (states: IDLE, REQUEST, STREAM)
- IDLE, FIFO empty: stay.
- IDLE, front flit is HEAD or HEADTAIL: register the routed port into `routeReserveRequest`, go to REQUEST.
- IDLE, front flit is BODY or TAIL: dequeue it, pulse `err_flit`, stay.
- REQUEST: `routeReserveRequestValid`=1 and `valid_out`=0. On `routeReserveStatus`, go to STREAM.
- STREAM: `routeReserveRequestValid`=1 and `valid_out` = ~empty. Flits dequeue on `valid_out & ready_out`.
- STREAM, handshake of a TAIL or HEADTAIL flit: `routeRelieve`=1 in that same cycle, go to IDLE.
- `routeReserveRequest` is held constant from IDLE exit until the cycle after the relieve pulse.

## Timing

**Reset values:** state IDLE, FIFO empty, and all outputs 0 except `ready_in`=1. Pointers and counters clear asynchronously.

**Latencies**
- Head written at edge t → `routeReserveRequestValid` high from t+2.
- Grant pulse sampled at edge g → `valid_out` high from g+1.
- FIFO write-to-read latency is 1 cycle.

**Handshake rules**
- `routeReserveRequestValid` is low for at least one cycle between packets, so the switch controller returns to its unrouted state.
- `routeRelieve` is exactly one cycle wide and occurs only in STREAM.
- A grant pulse outside REQUEST is ignored.
- A BODY or TAIL flit arriving while in STREAM is streamed normally.
- A HEAD flit encountered in STREAM is also streamed. No error is flagged; well-formed packets are an upstream requirement.

**Boundary cases**
- FIFO full with `valid_in`=1: `ready_in`=0 and no write.
- FIFO empty in STREAM: `valid_out`=0 and the path stays held.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Reset asserted mid-packet: return to IDLE immediately with no relieve pulse. The switch controller must be reset together with this block.

## Structure

**Shared package `noc_pkg`**
- Flit type encodings.
- Port index constants.
- FSM state encoding (2 bits).

**Sub-module `flit_fifo`**
- Parameterised by DATA_WIDTH and FIFO_DEPTH.
- Ports: push, pop, full, empty, front data.
- Instantiated once; the FSM and route logic live in the top level.

## Test plan

1. Router at (1,1); HEAD with dest (2,1), BODY, TAIL; grant 3 cycles after request.
   → request=1 (EAST), valid high from t+2. Three flits stream from the cycle after the grant. `routeRelieve` pulses on the TAIL handshake, then request valid drops.
2. Router at (1,1); HEADTAIL flits with dests (1,1), (0,1), (1,2), (1,0).
   → request = 0, 2, 3, 4 respectively, one relieve per packet. Request valid is low for ≥1 cycle between packets.
3. Push 6 flits back-to-back with FIFO_DEPTH=4 while no grant is given.
   → `ready_in` falls after the 4th write. Flits 5 and 6 are accepted only after streaming starts. Output order is preserved.
4. Drive `ready_out` low for 5 cycles in mid-packet.
   → `data_out` is held stable and no flit is lost. `routeRelieve` is delayed until the TAIL handshake.
5. Send a BODY flit while IDLE.
   → it is discarded, `err_flit` pulses once, and no request is raised.
6. Assert `rst` in STREAM after the 2nd flit.
   → immediately IDLE, FIFO empty, all outputs 0 except `ready_in`=1, and no relieve pulse.
